// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48A1 issue controller: FSM encoding,
// default OPMODE width and pipeline-depth helper.
package dsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH
  } seq_state_t;

  localparam int OPW_DEFAULT = 8;

  function automatic int calc_lat(input int ireg, input int mreg, input int preg);
    return ireg + mreg + preg;
  endfunction

endpackage

// File: rtl/dsp_token_pipe.sv
// Occupancy tracker for the slice pipeline: one token bit per present register
// stage, shifting toward the P stage while the pipeline advances.
module dsp_token_pipe #(
  parameter int LAT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv,
  input  logic           clr,
  input  logic           load,
  output logic [LAT-1:0] tok
);

  logic [LAT-1:0] tok_shift;

  generate
    if (LAT == 1) begin : g_single
      assign tok_shift = load;
    end else begin : g_multi
      assign tok_shift = {tok[LAT-2:0], load};
    end
  endgenerate

  // Clear wins over advance so a flush empties the pipe even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok <= '0;
    end else if (clr) begin
      tok <= '0;
    end else if (adv) begin
      tok <= tok_shift;
    end
  end

endmodule

// File: rtl/dsp_op_sequencer.sv
// Issue controller for the DSP48A1 slice: request handshake, per-stage clock
// enables, synchronous clear and result-valid tracking.
module dsp_op_sequencer
  import dsp_pkg::*;
#(
  parameter int IREG = 1,
  parameter int MREG = 1,
  parameter int PREG = 1,
  parameter int OPW  = OPW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_opmode,
  input  logic           flush,
  input  logic           res_ready,
  output logic           res_valid,
  output logic           ce_in,
  output logic           ce_m,
  output logic           ce_p,
  output logic           ce_opmode,
  output logic [OPW-1:0] opmode_out,
  output logic           stage_clr,
  output logic           busy
);

  localparam int LAT    = calc_lat(IREG, MREG, PREG);
  localparam int P_PREV = IREG + MREG - 1;

  generate
    if (LAT < 1) begin : g_lat_check
      $error("dsp_op_sequencer: at least one register stage must be present");
    end
  endgenerate

  seq_state_t     state, state_nxt;
  logic [LAT-1:0] tok;
  logic           adv;
  logic           accept;
  logic           opmode_match;

  dsp_token_pipe #(.LAT(LAT)) u_token_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .clr   (flush),
    .load  (accept),
    .tok   (tok)
  );

  assign res_valid    = tok[LAT-1];
  assign busy         = |tok;
  assign adv          = !(res_valid && !res_ready);
  assign opmode_match = (req_opmode == opmode_out);

  // A new OPMODE may only enter an empty pipe; DRAIN always defers it to IDLE.
  assign req_ready = rst_n && adv && !flush &&
                     ((state == ST_IDLE) || (state == ST_RUN)) &&
                     (!busy || opmode_match);
  assign accept    = req_valid && req_ready;
  assign ce_opmode = accept;

  generate
    if (IREG == 0) begin : g_ce_in_absent
      assign ce_in = 1'b1;
    end else begin : g_ce_in_present
      assign ce_in = accept;
    end

    if (MREG == 0) begin : g_ce_m_absent
      assign ce_m = 1'b1;
    end else if (IREG == 0) begin : g_ce_m_first
      assign ce_m = accept;
    end else begin : g_ce_m_follow
      assign ce_m = adv && tok[0];
    end

    if (PREG == 0) begin : g_ce_p_absent
      assign ce_p = 1'b1;
    end else if (P_PREV < 0) begin : g_ce_p_first
      assign ce_p = accept;
    end else begin : g_ce_p_follow
      assign ce_p = adv && tok[P_PREV];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush beats everything; a differing request in RUN forces a drain.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (flush)       state_nxt = ST_FLUSH;
        else if (accept) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (flush)                          state_nxt = ST_FLUSH;
        else if (accept)                    state_nxt = ST_RUN;
        else if (req_valid && !opmode_match) state_nxt = ST_DRAIN;
        else if (!busy)                     state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (flush)      state_nxt = ST_FLUSH;
        else if (!busy) state_nxt = ST_IDLE;
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opmode_out <= '0;
      stage_clr  <= 1'b0;
    end else begin
      stage_clr <= (state_nxt == ST_FLUSH);
      if (accept) begin
        opmode_out <= req_opmode;
      end
    end
  end

endmodule
